// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that serves two requesters on a cs/rd/oe chip-select memory.
// Control pins are registered so mem_a/mem_rd are stable around every mem_cs pulse.
module mem_port_arbiter #(
  parameter int unsigned AW = 2,
  parameter int unsigned DW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          r0_valid,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_ready,
  output logic          r0_done,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_valid,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_ready,
  output logic          r1_done,
  output logic [DW-1:0] r1_rdata,
  output logic          mem_cs,
  output logic          mem_rd,
  output logic          mem_oe,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_i,
  input  logic [DW-1:0] mem_o
);

  typedef enum logic [2:0] {
    StIdle,
    StWSetup,
    StWPulse,
    StWHold,
    StRSetup,
    StREn
  } state_e;

  state_e        state_q, state_d;
  logic          rr_ptr_q, rr_ptr_d;
  logic          id_q, id_d;
  logic          mem_cs_d, mem_rd_d, mem_oe_d;
  logic [AW-1:0] mem_a_d;
  logic [DW-1:0] mem_i_d;
  logic          r0_done_d, r1_done_d;
  logic [DW-1:0] r0_rdata_d, r1_rdata_d;

  logic          idle;
  logic          accept;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  // rr_ptr only breaks ties; a lone valid requester always wins.
  assign idle      = (state_q == StIdle);
  assign r0_ready  = idle & r0_valid & (~r1_valid | ~rr_ptr_q);
  assign r1_ready  = idle & r1_valid & (~r0_valid | rr_ptr_q);
  assign accept    = r0_ready | r1_ready;
  assign sel_we    = r1_ready ? r1_we    : r0_we;
  assign sel_addr  = r1_ready ? r1_addr  : r0_addr;
  assign sel_wdata = r1_ready ? r1_wdata : r0_wdata;

  // Next-state values are the pin levels for the state being entered.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    id_d       = id_q;
    mem_cs_d   = 1'b0;
    mem_oe_d   = 1'b0;
    mem_rd_d   = mem_rd;
    mem_a_d    = mem_a;
    mem_i_d    = mem_i;
    r0_done_d  = 1'b0;
    r1_done_d  = 1'b0;
    r0_rdata_d = r0_rdata;
    r1_rdata_d = r1_rdata;
    unique case (state_q)
      StIdle: begin
        mem_rd_d = 1'b1;
        if (accept) begin
          id_d     = r1_ready;
          rr_ptr_d = ~r1_ready;
          mem_a_d  = sel_addr;
          if (sel_we) begin
            mem_i_d  = sel_wdata;
            mem_rd_d = 1'b0;
            state_d  = StWSetup;
          end else begin
            state_d  = StRSetup;
          end
        end
      end
      StWSetup: begin
        mem_cs_d = 1'b1;
        mem_rd_d = 1'b0;
        state_d  = StWPulse;
      end
      StWPulse: begin
        mem_rd_d = 1'b0;
        state_d  = StWHold;
      end
      StWHold: begin
        mem_rd_d  = 1'b1;
        r0_done_d = ~id_q;
        r1_done_d = id_q;
        state_d   = StIdle;
      end
      StRSetup: begin
        mem_cs_d = 1'b1;
        mem_oe_d = 1'b1;
        mem_rd_d = 1'b1;
        state_d  = StREn;
      end
      StREn: begin
        mem_rd_d  = 1'b1;
        r0_done_d = ~id_q;
        r1_done_d = id_q;
        if (id_q) r1_rdata_d = mem_o;
        else      r0_rdata_d = mem_o;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      rr_ptr_q <= 1'b0;
      id_q     <= 1'b0;
      mem_cs   <= 1'b0;
      mem_rd   <= 1'b1;
      mem_oe   <= 1'b0;
      mem_a    <= '0;
      mem_i    <= '0;
      r0_done  <= 1'b0;
      r1_done  <= 1'b0;
      r0_rdata <= '0;
      r1_rdata <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      mem_cs   <= mem_cs_d;
      mem_rd   <= mem_rd_d;
      mem_oe   <= mem_oe_d;
      mem_a    <= mem_a_d;
      mem_i    <= mem_i_d;
      r0_done  <= r0_done_d;
      r1_done  <= r1_done_d;
      r0_rdata <= r0_rdata_d;
      r1_rdata <= r1_rdata_d;
    end
  end

endmodule
